// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-lane one-entry holding
// registers and a saturating counter for words addressed to absent lanes.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_data/in_sel  input word and its destination lane
//   in_valid        input word present
//   in_ready        block accepts the word this cycle (0 while rst=1)
//   out_data        lane k occupies bits [k*WIDTH +: WIDTH]
//   out_valid       lane k holds a word
//   out_ready       lane k sink accepts its word
//   drop_pulse      one-cycle pulse after an out-of-range word is consumed
//   drop_cnt        saturating count of dropped words
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 2,
  parameter int SEL_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   drop_pulse,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic [N_OUT-1:0] full;
  logic [WIDTH-1:0] data [N_OUT];
  logic [N_OUT-1:0] hit;
  logic             sel_ok;
  logic             lane_free;
  logic             accept;
  logic             drop;

  // Decode by comparing against every lane index so an out-of-range
  // select never indexes past the lane arrays; no hit means sel_ok=0.
  always_comb begin
    hit       = '0;
    lane_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        hit[k]    = 1'b1;
        lane_free = !full[k] || out_ready[k];
      end
    end
  end

  assign sel_ok   = |hit;
  assign in_ready = !rst && (sel_ok ? lane_free : 1'b1);
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic push;
    logic pop;

    assign push = accept && hit[k];
    assign pop  = full[k] && out_ready[k];

    // A push in the same cycle as a pop keeps the lane full with the
    // new word, giving pass-through without a bubble.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full[k] <= 1'b0;
        data[k] <= '0;
      end else if (push) begin
        full[k] <= 1'b1;
        data[k] <= in_data;
      end else if (pop) begin
        full[k] <= 1'b0;
      end
    end

    assign out_data[k*WIDTH +: WIDTH] = data[k];
  end

  assign out_valid = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a
// constrained-random run against a per-lane queue reference model.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [3:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic        drop_pulse;
  logic [7:0]  drop_cnt;

  stream_demux #(
    .WIDTH(8), .N_OUT(2), .SEL_W(4), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_pulse(drop_pulse),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         exp_cnt   = 0;
  logic       exp_pulse = 1'b0;
  logic [1:0] stall     = 2'b00;
  logic [7:0] prev [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(posedge clk) begin
    if (!rst && in_valid)
      assert (!$isunknown(in_sel)) else $error("in_sel unknown with in_valid");
  end

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: compare outputs against model state, then apply
  // the handshakes that will take effect at the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_cnt   = 0;
      exp_pulse = 1'b0;
      stall     = 2'b00;
    end else begin
      logic ok;
      logic rdy;
      logic [7:0] e;
      check("drop_cnt", drop_cnt, exp_cnt);
      check("drop_pulse", drop_pulse, exp_pulse);
      ok  = in_sel < 4'd2;
      rdy = ok ? (qsize(int'(in_sel)) == 0 || out_ready[in_sel[0]]) : 1'b1;
      check("in_ready", in_ready, rdy);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("out_valid%0d", k), out_valid[k], qsize(k) != 0);
        if (stall[k])
          check($sformatf("stable%0d", k), out_data[k*8 +: 8], prev[k]);
        if (out_valid[k] && out_ready[k]) begin
          if (qsize(k) == 0) begin
            check($sformatf("dup%0d", k), 1, 0);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("lane%0d_data", k), out_data[k*8 +: 8], e);
            n_deliv++;
          end
        end
        stall[k] = out_valid[k] && !out_ready[k];
        prev[k]  = out_data[k*8 +: 8];
      end
      exp_pulse = 1'b0;
      if (in_valid && rdy) begin
        if (!ok) begin
          exp_pulse = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end else if (in_sel == 4'd0) q0.push_back(in_data);
        else q1.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [3:0] s, logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    out_ready = 2'b00;
    drive(1'b0, 4'd0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single word to lane 1
    out_ready = 2'b11;
    drive(1'b1, 4'd1, 8'hA5);
    #1 check("t1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 2'b10);
    check("t1_data", out_data[15:8], 8'hA5);
    step();
    check("t1_empty", out_valid, 2'b00);

    // Backpressure on lane 0
    out_ready = 2'b10;
    drive(1'b1, 4'd0, 8'h11);
    step();
    drive(1'b1, 4'd0, 8'h22);
    #1 check("bp_in_ready", in_ready, 0);
    check("bp_hold", out_data[7:0], 8'h11);
    drive(1'b1, 4'd1, 8'h33);
    #1 check("bp_other_rdy", in_ready, 1);
    step();
    check("bp_l1_valid", out_valid[1], 1);
    check("bp_l1_data", out_data[15:8], 8'h33);
    check("bp_l0_hold", out_data[7:0], 8'h11);
    drive(1'b1, 4'd0, 8'h22);
    out_ready = 2'b11;
    #1 check("bp_pass_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_l0_valid", out_valid[0], 1);
    check("bp_l0_data", out_data[7:0], 8'h22);
    step();

    // Streaming, alternating lanes
    base = n_deliv;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i % 2), 8'(8'h40 + i));
      #1 check("stream_rdy", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("stream_count", n_deliv - base, 16);

    // Out-of-range drop and saturation
    drive(1'b1, 4'd3, 8'hFF);
    #1 check("drop_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("drop_pulse1", drop_pulse, 1);
    check("drop_cnt1", drop_cnt, 1);
    check("drop_noval", out_valid, 0);
    step();
    check("drop_pulse0", drop_pulse, 0);
    drive(1'b1, 4'd3, 8'hFF);
    repeat (300) step();
    in_valid = 1'b0;
    step();
    check("drop_sat", drop_cnt, 255);

    // Asynchronous reset with lanes stalled
    out_ready = 2'b00;
    drive(1'b1, 4'd0, 8'h55);
    step();
    drive(1'b1, 4'd1, 8'h66);
    step();
    in_valid = 1'b0;
    check("pre_rst_full", out_valid, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_cnt", drop_cnt, 0);
    check("arst_rdy", in_ready, 0);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    out_ready = 2'b11;
    drive(1'b1, 4'd0, 8'hA5);
    #1 check("post_rst_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 2'b01);
    check("post_rst_data", out_data[7:0], 8'hA5);
    step();
    check("post_rst_empty", out_valid, 0);

    // Constrained random
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
            8'($urandom));
      out_ready = 2'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 2'b11;
    repeat (4) step();
    check("rnd_q0_empty", q0.size(), 0);
    check("rnd_q1_empty", q1.size(), 0);
    check("rnd_drop_cnt", drop_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer: the receive-side counterpart of the team's 2:1 select mux.
- A single valid/ready input stream carries a per-word select tag. The block routes each word to the addressed output lane.
- Each output lane has its own one-entry holding register, so a stalled lane never blocks words addressed to other lanes once its register drains.
- Words whose select is out of range are consumed, dropped, flagged and counted.

Parameters:
- WIDTH, 8, data word width in bits.
- N_OUT, 2, number of output lanes (2..16).
- SEL_W, 4, width of in_sel; must satisfy 2**SEL_W >= N_OUT.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination lane for in_data.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  N_OUT*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  N_OUT  lane k holds a word.
- out_ready  input  N_OUT  lane k sink accepts its word.
- drop_pulse  output  1  one-cycle pulse, one clock after an out-of-range word is consumed.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately and holds while rst=1.
  - All out_valid = 0, out_data = 0, drop_pulse = 0, drop_cnt = 0.
  - A word in flight is lost; no partial handshake survives reset.
  - While rst=1, in_ready = 0.
- Lane k state: full_k (drives out_valid[k]) and data_k.
- Lane k pops when full_k && out_ready[k]; full_k clears next edge unless a push to lane k occurs in the same cycle.
- Range check: sel_ok = (in_sel < N_OUT).
- in_ready (combinational, not dependent on in_valid):
  - sel_ok: in_ready = !full[in_sel] || out_ready[in_sel]. Pass-through on a simultaneous pop.
  - !sel_ok: in_ready = 1.
- Accept = in_valid && in_ready.
- Push, sel_ok: data_k <= in_data, full_k <= 1. Simultaneous pop and push on the same lane leaves full_k = 1 with the new data (no bubble, no loss).
- Drop, !sel_ok:
  - Word is discarded.
  - drop_pulse = 1 for exactly the next cycle.
  - drop_cnt increments by 1, saturating at 2**CNT_W-1 (no wrap).
- Latency: an accepted word appears on out_valid/out_data on the next clock edge. Throughput is 1 word/clock when the destination lane drains each cycle.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data lane k is held constant. Other lanes continue independently.
- out_data of an empty lane holds its last value. Sinks must qualify with out_valid.
- No ordering guarantee across lanes; order within a lane is preserved.
- Input values are ignored when in_valid=0; no state changes.
- X on in_sel with in_valid=1 is a protocol violation; the bench asserts against it.

Test Plan:
- Reset, then in_valid=1, in_sel=1, in_data=0xA5, all out_ready=1:
  - in_ready=1.
  - Next cycle out_valid=2'b10, lane1 data=0xA5.
  - Following cycle out_valid=0.
- Backpressure:
  - Lane0 with out_ready[0]=0: push 0x11 to lane0, then offer 0x22 to lane0 → in_ready=0 and lane0 holds 0x11.
  - Offer 0x33 to lane1 in the same stall → accepted and appears on lane1 next cycle.
  - Raise out_ready[0] → 0x22 accepted in the same cycle (pass-through), lane0 shows 0x22 next cycle.
- Streaming: 16 back-to-back words alternating sel 0/1, all out_ready=1 → one accept per clock; each lane sees its 8 words in order with 1-cycle latency.
- Out of range: N_OUT=2, in_sel=3, in_data=0xFF → in_ready=1, no out_valid change, drop_pulse high one cycle, drop_cnt=1. Then 300 such words → drop_cnt saturates at 255.
- Reset mid-operation:
  - Lanes full and stalled, assert rst between clock edges → out_valid=0 and drop_cnt=0 immediately, before the next edge.
  - After release, a push to lane0 behaves as in the first scenario.
- Random: constrained-random sel (including out-of-range), random in_valid/out_ready over 10k cycles.
  - Scoreboard: per-lane in-order delivery, no loss or duplication.
  - Drop count matches expected.
  - out_data stable under stall.
